pipelined_addsub_n: RTL and testbench
=====================================

Name: pipelined_addsub_n

Overview:
- Parametrised, pipelined signed adder/subtractor. Computes S = A + B (k=0) or S = A - B (k=1) on N-bit two's-complement operands, producing an (N+1)-bit sign-extended result.
- Next generation of the team's single-cycle ripple add/sub. The carry chain is split across STAGES register stages, with valid/ready handshakes on input and output.
- Sits between operand-producing datapath blocks and ALU/accumulator consumers. Accepts one operation per cycle when not stalled.

Parameters:
- N, 8, operand width in bits (N >= 2).
- STAGES, 2, number of pipeline stages / carry-chain chunks (1 <= STAGES <= N+1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set {A,B,k} presented
- in_ready  output  1  block can accept an operand set this cycle
- A  input  N  signed operand
- B  input  N  signed operand
- k  input  1  mode: 0 = add, 1 = subtract
- out_valid  output  1  S/ovf hold a valid result
- out_ready  input  1  consumer accepts the result this cycle
- S  output  N+1  signed result, sign-extended
- ovf  output  1  N-bit overflow flag (see Optional Feature)

Behaviour:
- Reset: asynchronous on rst_n low; all stage valid bits = 0, out_valid = 0, S = 0, ovf = 0, all internal carry/data registers = 0. Release is synchronous to clk.
- Width rules:
  - A and B are sign-extended to N+1 bits.
  - Subtract = A1 + ~B1 + 1, with carry-in = k.
  - Final carry-out is discarded.
  - The (N+1)-bit result never wraps.
- Chunking:
  - CW = ceil((N+1)/STAGES).
  - Chunk i covers bits [i*CW, min((i+1)*CW, N+1)-1]; the last chunk may be shorter.
  - Stage i adds chunk i using the registered carry from stage i-1.
  - Unprocessed upper operand chunks and already-computed lower result bits travel down the pipeline with the operation (skewed pipeline).
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid = 1, when no stall occurs.
- Throughput: one operation per cycle.
- Advance control:
  - advance = ~out_valid | out_ready.
  - in_ready = advance (combinational from out_valid and out_ready).
  - On advance, every stage shifts one position. Bubbles (valid = 0) shift like data.
  - When advance = 0, all stages hold their contents.
- Handshake rules:
  - A transfer occurs on a rising edge with valid & ready both high.
  - S and ovf are stable while out_valid = 1 and out_ready = 0.
  - in_valid low with in_ready high inserts a bubble.
- k is captured per operation, so mixed add/sub streams are allowed back-to-back.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- Reset mid-operation: all in-flight operations are dropped, with no partial output.
- STAGES = 1: combinational add, registered once; latency 1.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined:
  - Final stage checks whether the (N+1)-bit result fits in N bits, i.e. S[N] == S[N-1].
  - If it does not fit, S is clamped to sign-extended 2^(N-1)-1 (positive overflow) or -2^(N-1) (negative overflow), and ovf = 1 for that result.
  - Otherwise ovf = 0 and S is unchanged.
- Not defined: S is the exact (N+1)-bit result, ovf is tied to 0, and no saturation logic is generated.

Test Plan:
- N=8, STAGES=2, out_ready=1: A=0x7F, B=0x01, k=0 -> after 2 cycles out_valid=1, S=0x080. With ADDSUB_SAT_EN: S=0x07F, ovf=1.
- A=0x80, B=0x01, k=1 -> S=0x17F (-129). With ADDSUB_SAT_EN: S=0x180 (-128), ovf=1.
- Back-to-back stream of 4 ops {(5,3,0),(5,3,1),(0xFF,0xFF,0),(0x00,0x01,1)} -> S = 0x008, 0x002, 0x1FE, 0x1FF on 4 consecutive cycles, first at cycle 2.
- Stall: out_ready=0 while a result is valid, in_valid=1 -> in_ready=0; S holds its value; no operation is lost or duplicated after out_ready returns to 1.
- rst_n pulsed low for 1 cycle with 2 ops in flight -> out_valid, S and ovf go to 0 immediately; no stale result appears after release.
- Sweep STAGES in {1, 3, 9} with N=8, using random A/B/k against a reference model -> S is bit-exact and latency equals STAGES.

Source files
------------

// File: rtl/pipelined_addsub_n_if.sv
// Handshake and operand/result bundle for pipelined_addsub_n.
// The slave side belongs to the adder. The master side belongs to whoever produces operands and consumes results.
interface pipelined_addsub_n_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         k;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   S;
    logic         ovf;

    modport master (
        output in_valid, A, B, k, out_ready,
        input  in_ready, out_valid, S, ovf
    );

    modport slave (
        input  in_valid, A, B, k, out_ready,
        output in_ready, out_valid, S, ovf
    );
endinterface

// File: rtl/pipelined_addsub_n.sv
// Pipelined signed add/sub. The (N+1)-bit carry chain is cut into STAGES chunks, forming a skewed pipeline.
// Optional ADDSUB_SAT_EN: clamp results that do not fit in N bits and raise ovf.
module pipelined_addsub_n #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_addsub_n_if.slave    bus
);
    localparam int W  = N + 1;
    localparam int CW = (W + STAGES - 1) / STAGES;

    logic         advance;
    logic         out_valid;
    logic [W-1:0] res;

    assign advance      = ~out_valid | bus.out_ready;
    assign bus.in_ready = advance;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO  = (gi * CW < W) ? gi * CW : W;
            localparam int HI1 = ((gi + 1) * CW < W) ? (gi + 1) * CW : W;
            localparam int CL  = HI1 - LO;

            logic           valid_q, valid_d;
            logic [HI1-1:0] sum_q, sum_d;

            if (gi == 0) begin : g_vld
                always_comb valid_d = advance ? bus.in_valid : valid_q;
            end else begin : g_vld
                always_comb valid_d = advance ? g_stage[gi-1].valid_q : valid_q;
            end

            if (CL > 0) begin : g_chunk
                // Operand bits not yet added, carried alongside the partial sum.
                logic [W-LO-1:0] src_a, src_b;
                logic            src_carry;
                logic [CL-1:0]   part;

                if (gi == 0) begin : g_in
                    assign src_a     = {bus.A[N-1], bus.A};
                    assign src_b     = {bus.B[N-1], bus.B} ^ {W{bus.k}};
                    assign src_carry = bus.k;
                    always_comb sum_d = advance ? part : sum_q;
                end else begin : g_in
                    assign src_a     = g_stage[gi-1].g_chunk.g_fwd.a_q;
                    assign src_b     = g_stage[gi-1].g_chunk.g_fwd.b_q;
                    assign src_carry = g_stage[gi-1].g_chunk.g_fwd.carry_q;
                    always_comb sum_d = advance ? {part, g_stage[gi-1].sum_q} : sum_q;
                end

                if (HI1 < W) begin : g_fwd
                    typedef logic [CL:0] total_t;
                    total_t            total;
                    logic [W-HI1-1:0]  a_q, a_d, b_q, b_d;
                    logic              carry_q, carry_d;

                    always_comb begin
                        total   = total_t'(src_a[CL-1:0]) + total_t'(src_b[CL-1:0])
                                + total_t'(src_carry);
                        part    = total[CL-1:0];
                        a_d     = advance ? src_a[W-LO-1:CL] : a_q;
                        b_d     = advance ? src_b[W-LO-1:CL] : b_q;
                        carry_d = advance ? total[CL] : carry_q;
                    end

                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) begin
                            a_q     <= '0;
                            b_q     <= '0;
                            carry_q <= 1'b0;
                        end else begin
                            a_q     <= a_d;
                            b_q     <= b_d;
                            carry_q <= carry_d;
                        end
                    end
                end else begin : g_last
                    // Top chunk: the carry out of the sign bit is dropped.
                    typedef logic [CL-1:0] chunk_t;
                    always_comb part = src_a + src_b + chunk_t'(src_carry);
                end
            end else begin : g_empty
                always_comb sum_d = advance ? g_stage[gi-1].sum_q : sum_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    sum_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    sum_q   <= sum_d;
                end
            end
        end
    endgenerate

    assign out_valid     = g_stage[STAGES-1].valid_q;
    assign res           = g_stage[STAGES-1].sum_q;
    assign bus.out_valid = out_valid;

`ifdef ADDSUB_SAT_EN
    logic sat_ovf;
    always_comb begin
        sat_ovf = res[N] ^ res[N-1];
        bus.S   = res;
        if (sat_ovf) begin
            bus.S = res[N] ? {2'b11, {(N-1){1'b0}}} : {2'b00, {(N-1){1'b1}}};
        end
        bus.ovf = sat_ovf;
    end
`else
    assign bus.S   = res;
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_addsub_n.sv
// Bench for pipelined_addsub_n: four instances (STAGES = 1, 2, 3, 9) share operands, each with its own consumer.
// Each instance is scored against an arithmetic model.
`timescale 1ns/1ps
module tb_pipelined_addsub_n;
    localparam int N    = 8;
    localparam int NDUT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid_drv;
    logic [N-1:0]    a_drv, b_drv;
    logic            k_drv;
    logic [NDUT-1:0] ready_drv;
    logic            lat_check;
    int              n_checks = 0;
    int              n_bad    = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [N:0] s;
        logic       ovf;
        int         t;
    } exp_t;

`ifdef ADDSUB_SAT_EN
    localparam logic [N:0] T1_S = 9'h07F;
    localparam logic       T1_O = 1'b1;
    localparam logic [N:0] T2_S = 9'h180;
    localparam logic       T2_O = 1'b1;
`else
    localparam logic [N:0] T1_S = 9'h080;
    localparam logic       T1_O = 1'b0;
    localparam logic [N:0] T2_S = 9'h17F;
    localparam logic       T2_O = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic k, input int t);
        exp_t e;
        int   r;
        r     = k ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        e.ovf = 1'b0;
`ifdef ADDSUB_SAT_EN
        if (r > 2**(N-1) - 1) begin
            r     = 2**(N-1) - 1;
            e.ovf = 1'b1;
        end else if (r < -(2**(N-1))) begin
            r     = -(2**(N-1));
            e.ovf = 1'b1;
        end
`endif
        e.s = r[N:0];
        e.t = t;
        return e;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int ST = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 9;

            pipelined_addsub_n_if #(.N(N)) bus ();

            assign bus.in_valid  = in_valid_drv;
            assign bus.A         = a_drv;
            assign bus.B         = b_drv;
            assign bus.k         = k_drv;
            assign bus.out_ready = ready_drv[gi];

            pipelined_addsub_n #(.N(N), .STAGES(ST)) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus)
            );

            exp_t       exp_q[$];
            int         cyc       = 0;
            logic       hold_pend = 1'b0;
            logic [N:0] hold_s    = '0;

            always @(negedge clk) begin
                exp_t e;
                if (!rst_n) begin
                    exp_q.delete();
                    hold_pend = 1'b0;
                end else begin
                    if (hold_pend) begin
                        check_val($sformatf("st%0d_hold_valid", ST), 32'(bus.out_valid), 1);
                        check_val($sformatf("st%0d_hold_S", ST), 32'(bus.S), 32'(hold_s));
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            check_val($sformatf("st%0d_spurious_out", ST), 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check_val($sformatf("st%0d_S", ST), 32'(bus.S), 32'(e.s));
                            check_val($sformatf("st%0d_ovf", ST), 32'(bus.ovf), 32'(e.ovf));
                            if (lat_check)
                                check_val($sformatf("st%0d_latency", ST), cyc - e.t, ST);
                        end
                    end
                    hold_pend = bus.out_valid && !bus.out_ready;
                    hold_s    = bus.S;
                    if (bus.in_valid && bus.in_ready)
                        exp_q.push_back(model(bus.A, bus.B, bus.k, cyc));
                end
                cyc++;
            end
        end
    endgenerate

    task automatic drive_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic k);
        a_drv        = a;
        b_drv        = b;
        k_drv        = k;
        in_valid_drv = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] pick_operand();
        logic [N-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 8'h7F;
            1:       v = 8'h80;
            2:       v = 8'hFF;
            3:       v = 8'h00;
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    logic [N:0] stream_s [4];

    initial begin
        stream_s[0] = 9'h008;
        stream_s[1] = 9'h002;
        stream_s[2] = 9'h1FE;
        stream_s[3] = 9'h1FF;

        rst_n        = 1'b0;
        in_valid_drv = 1'b0;
        a_drv        = '0;
        b_drv        = '0;
        k_drv        = 1'b0;
        ready_drv    = '1;
        lat_check    = 1'b1;
        #1;
        check_val("rst_out_valid", 32'(g_dut[1].bus.out_valid), 0);
        check_val("rst_S", 32'(g_dut[1].bus.S), 0);
        check_val("rst_ovf", 32'(g_dut[1].bus.ovf), 0);
        check_val("rst_in_ready", 32'(g_dut[1].bus.in_ready), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();

        // Positive overflow of the N-bit range.
        drive_op(8'h7F, 8'h01, 1'b0);
        next_cycle();
        in_valid_drv = 1'b0;
        check_val("t1_not_early", 32'(g_dut[1].bus.out_valid), 0);
        next_cycle();
        check_val("t1_valid", 32'(g_dut[1].bus.out_valid), 1);
        check_val("t1_S", 32'(g_dut[1].bus.S), 32'(T1_S));
        check_val("t1_ovf", 32'(g_dut[1].bus.ovf), 32'(T1_O));
        repeat (10) next_cycle();

        // Negative overflow via subtraction.
        drive_op(8'h80, 8'h01, 1'b1);
        next_cycle();
        in_valid_drv = 1'b0;
        next_cycle();
        check_val("t2_valid", 32'(g_dut[1].bus.out_valid), 1);
        check_val("t2_S", 32'(g_dut[1].bus.S), 32'(T2_S));
        check_val("t2_ovf", 32'(g_dut[1].bus.ovf), 32'(T2_O));
        repeat (10) next_cycle();

        // Back-to-back mixed add/sub stream.
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive_op(8'h05, 8'h03, 1'b0);
                1: drive_op(8'h05, 8'h03, 1'b1);
                2: drive_op(8'hFF, 8'hFF, 1'b0);
                default: drive_op(8'h00, 8'h01, 1'b1);
            endcase
            next_cycle();
            if (i >= 1) begin
                check_val($sformatf("stream_valid%0d", i - 1), 32'(g_dut[1].bus.out_valid), 1);
                check_val($sformatf("stream_S%0d", i - 1), 32'(g_dut[1].bus.S), 32'(stream_s[i-1]));
            end
        end
        in_valid_drv = 1'b0;
        next_cycle();
        check_val("stream_valid3", 32'(g_dut[1].bus.out_valid), 1);
        check_val("stream_S3", 32'(g_dut[1].bus.S), 32'(stream_s[3]));
        repeat (12) next_cycle();

        // Consumer stall with the producer still offering work.
        lat_check = 1'b0;
        ready_drv = '0;
        drive_op(8'h03, 8'h04, 1'b0);
        next_cycle();
        drive_op(8'h0A, 8'h02, 1'b1);
        next_cycle();
        check_val("stall_valid", 32'(g_dut[1].bus.out_valid), 1);
        check_val("stall_S", 32'(g_dut[1].bus.S), 32'h007);
        check_val("stall_in_ready", 32'(g_dut[1].bus.in_ready), 0);
        repeat (3) begin
            next_cycle();
            check_val("stall_hold_S", 32'(g_dut[1].bus.S), 32'h007);
            check_val("stall_hold_in_ready", 32'(g_dut[1].bus.in_ready), 0);
        end
        in_valid_drv = 1'b0;
        ready_drv    = '1;
        repeat (12) next_cycle();
        lat_check = 1'b1;

        // Reset with two operations in flight.
        drive_op(8'h11, 8'h22, 1'b0);
        next_cycle();
        drive_op(8'h33, 8'h01, 1'b1);
        next_cycle();
        in_valid_drv = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_val("midrst_out_valid", 32'(g_dut[1].bus.out_valid), 0);
        check_val("midrst_S", 32'(g_dut[1].bus.S), 0);
        check_val("midrst_ovf", 32'(g_dut[1].bus.ovf), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) begin
            next_cycle();
            check_val("post_rst_idle",
                      32'({g_dut[3].bus.out_valid, g_dut[2].bus.out_valid,
                           g_dut[1].bus.out_valid, g_dut[0].bus.out_valid}), 0);
        end

        // Random traffic, consumer always ready: exact latency checked.
        repeat (300) begin
            drive_op(pick_operand(), pick_operand(), 1'($urandom));
            in_valid_drv = ($urandom_range(0, 9) < 7);
            next_cycle();
        end
        in_valid_drv = 1'b0;
        repeat (12) next_cycle();

        // Random traffic with random consumer back-pressure.
        lat_check = 1'b0;
        repeat (600) begin
            drive_op(pick_operand(), pick_operand(), 1'($urandom));
            in_valid_drv = ($urandom_range(0, 9) < 7);
            ready_drv    = 4'($urandom);
            next_cycle();
        end
        in_valid_drv = 1'b0;
        ready_drv    = '1;
        repeat (20) next_cycle();

        check_val("st1_drain", g_dut[0].exp_q.size(), 0);
        check_val("st2_drain", g_dut[1].exp_q.size(), 0);
        check_val("st3_drain", g_dut[2].exp_q.size(), 0);
        check_val("st9_drain", g_dut[3].exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
